// File: rtl/sevenseg_scan_driver.sv
// Two-digit multiplexed 7-segment scan driver: synchronised, glitch-filtered BCD input,
// frame-atomic display update, slot blanking, leading-zero suppression and blinking.
module sevenseg_scan_driver #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 128,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_units,
  input  logic       lz_blank_en,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       frame_tick
);

  localparam int unsigned CNT_W     = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic        POL       = (ACTIVE_LOW != 0);
  localparam logic [6:0]  SEG_UNLIT = {7{POL}};
  localparam logic [1:0]  DIG_UNLIT = {2{POL}};

  typedef enum logic {
    SLOT_TENS  = 1'b0,
    SLOT_UNITS = 1'b1
  } slot_e;

  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [7:0]       r_s3;
  logic [7:0]       r_cand;
  logic [7:0]       r_disp;
  logic [CNT_W-1:0] r_div_cnt;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_off;
  slot_e            r_slot;
  slot_e            w_slot_next;
  logic [6:0]       r_seg;
  logic [1:0]       r_dig_sel;
  logic             r_frame_tick;

  logic             w_stable;
  logic [7:0]       w_cand;
  logic             w_wrap;
  logic             w_boundary;
  logic             w_blank;
  logic             w_lz;
  logic             w_dark;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_ah;
  logic [1:0]       w_dig_ah;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h40;
    endcase
  endfunction

  // A value is a candidate only once it has been identical in two consecutive samples
  assign w_stable = (r_s2 == r_s3);
  assign w_cand   = w_stable ? r_s2 : r_cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 8'h00;
      r_s2   <= 8'h00;
      r_s3   <= 8'h00;
      r_cand <= 8'h00;
    end else begin
      r_s1   <= {bcd_tens, bcd_units};
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_cand <= w_cand;
    end
  end

  assign w_wrap     = (r_div_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_boundary = w_wrap && (r_slot == SLOT_UNITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  // Slot sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= SLOT_TENS;
    end else begin
      r_slot <= w_slot_next;
    end
  end

  // Slot sequencer: next state
  always_comb begin
    w_slot_next = r_slot;
    if (w_wrap) begin
      w_slot_next = (r_slot == SLOT_TENS) ? SLOT_UNITS : SLOT_TENS;
    end
  end

  // Displayed value only changes between frames, so a frame never mixes two values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp <= 8'h00;
    end else if (w_boundary) begin
      r_disp <= w_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (!blink_en) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_boundary) begin
      if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  // Slot sequencer: outputs (active-high, before polarity and registering)
  always_comb begin
    w_blank  = (r_div_cnt < CNT_W'(BLANK_CYCLES));
    w_lz     = (r_slot == SLOT_TENS) && lz_blank_en && (r_disp[7:4] == 4'd0);
    w_dark   = w_blank || (blink_en && r_blink_off) || w_lz;
    w_digit  = (r_slot == SLOT_UNITS) ? r_disp[3:0] : r_disp[7:4];
    w_seg_ah = 7'h00;
    w_dig_ah = 2'b00;
    if (!w_dark) begin
      w_seg_ah = f_decode(w_digit);
      w_dig_ah = (r_slot == SLOT_UNITS) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_UNLIT;
      r_dig_sel    <= DIG_UNLIT;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_ah ^ SEG_UNLIT;
      r_dig_sel    <= w_dig_ah ^ DIG_UNLIT;
      r_frame_tick <= w_boundary;
    end
  end

  assign seg        = r_seg;
  assign dig_sel    = r_dig_sel;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver: directed scenarios plus random input
// traffic, compared every cycle against a frame-level reference model.
module tb_sevenseg_scan_driver;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned BF = 2;
  localparam int unsigned AL = 0;
  localparam int unsigned FRAME = 2 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tens = 4'd0;
  logic [3:0] units = 4'd0;
  logic       lz = 1'b0;
  logic       blink = 1'b0;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  // Model state: cycle index since reset release, input history, shown value
  int         t = 0;
  logic [7:0] hist[$];
  logic [7:0] m_cand = 8'h00;
  logic [7:0] m_disp = 8'h00;
  int         bcount = 0;

  sevenseg_scan_driver #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst(rst), .bcd_tens(tens), .bcd_units(units),
    .lz_blank_en(lz), .blink_en(blink),
    .seg(seg), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [7:0] val(input int i);
    if (i < 0) return 8'h00;
    return hist[i];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the registered outputs from the current cycle, advance model, compare
  task automatic tick();
    int         j;
    int         div;
    int         slot;
    logic       off;
    logic       dark;
    logic       bnd;
    logic [3:0] digit;
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    logic [6:0] pol7;
    logic [1:0] pol2;
    j = t;
    hist.push_back({tens, units});
    div   = j % SD;
    slot  = (j / SD) % 2;
    bnd   = ((j % FRAME) == FRAME - 1);
    off   = blink && (((bcount / BF) % 2) == 1);
    dark  = (div < BC) || off || (slot == 0 && lz && m_disp[7:4] == 4'd0);
    digit = (slot == 1) ? m_disp[3:0] : m_disp[7:4];
    e_seg = dark ? 7'h00 : dec(digit);
    e_dig = dark ? 2'b00 : ((slot == 1) ? 2'b01 : 2'b10);
    pol7  = (AL != 0) ? 7'h7F : 7'h00;
    pol2  = (AL != 0) ? 2'b11 : 2'b00;
    if (val(j - 2) == val(j - 3)) m_cand = val(j - 2);
    if (bnd) m_disp = m_cand;
    if (!blink) bcount = 0;
    else if (bnd) bcount++;
    t++;
    @(posedge clk);
    #1;
    chk("seg", {1'b0, seg}, {1'b0, e_seg ^ pol7});
    chk("dig_sel", {6'd0, dig_sel}, {6'd0, e_dig ^ pol2});
    chk("frame_tick", {7'd0, frame_tick}, {7'd0, bnd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_phase(input int ph);
    while ((t % FRAME) != ph) tick();
  endtask

  task automatic model_reset();
    t = 0;
    hist.delete();
    m_cand = 8'h00;
    m_disp = 8'h00;
    bcount = 0;
  endtask

  initial begin
    int ft_cnt;
    int both_cnt;
    int seen_6d;
    // 1: reset state, then 42 displayed
    tens = 4'd4;
    units = 4'd2;
    #1;
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_dig", {6'd0, dig_sel}, 8'h00);
    chk("rst_ft", {7'd0, frame_tick}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_seg", {1'b0, seg}, 8'h00);
    model_reset();
    rst = 1'b0;
    run(48);

    // 2: free run, frame_tick period and digit exclusivity
    ft_cnt = 0;
    both_cnt = 0;
    for (int i = 0; i < 10 * FRAME; i++) begin
      tick();
      if (frame_tick === 1'b1) ft_cnt++;
      if (dig_sel === 2'b11) both_cnt++;
    end
    chk("ft_count", 8'(ft_cnt), 8'd10);
    chk("dig_both", 8'(both_cnt), 8'd0);

    // 3: leading-zero suppression on and off
    tens = 4'd0;
    units = 4'd7;
    lz = 1'b1;
    run(48);
    lz = 1'b0;
    run(32);

    // 4: invalid digit dash, then a one-cycle glitch that must not appear
    tens = 4'd1;
    units = 4'hC;
    run(48);
    units = 4'd5;
    tick();
    units = 4'hC;
    seen_6d = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (seg === 7'h6D) seen_6d++;
    end
    chk("glitch_6d", 8'(seen_6d), 8'd0);

    // 5: change mid-units-slot, no mixed frame
    tens = 4'd4;
    units = 4'd2;
    run(40);
    run_to_phase(12);
    tens = 4'd3;
    units = 4'd1;
    run(48);

    // 6: blink from a frame start, release during a dark phase
    run_to_phase(0);
    blink = 1'b1;
    run(4 * FRAME + 20);
    while (((bcount / BF) % 2) != 1) tick();
    run(5);
    blink = 1'b0;
    run(2 * FRAME);

    // 6: asynchronous reset during a lit tens cycle
    run_to_phase(5);
    rst = 1'b1;
    #1;
    chk("arst_seg", {1'b0, seg}, 8'h00);
    chk("arst_dig", {6'd0, dig_sel}, 8'h00);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    run(3 * FRAME);

    // Random traffic: held values, short glitches, live control toggles
    for (int k = 0; k < 120; k++) begin
      tens  = 4'($urandom_range(0, 15));
      units = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) lz = ~lz;
      if ($urandom_range(0, 4) == 0) blink = ~blink;
      run(int'($urandom_range(1, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Downstream display stage for the mental-math game. It consumes the two BCD digits produced by the game core (tens, units) and drives a two-digit, common-anode/cathode multiplexed 7-segment display from the fast board clock. It provides:
- input synchronisation and stability filtering
- tear-free frame updates
- ghost-suppression blanking
- leading-zero suppression
- invalid-digit dash display
- optional blinking

Parameters:
SCAN_DIV, 1000, clk cycles per digit slot; legal range >= 2.
BLANK_CYCLES, 16, dark cycles at start of each slot; legal range 0 .. SCAN_DIV-1.
BLINK_FRAMES, 128, frames per blink phase (on or off); legal range >= 1.
ACTIVE_LOW, 1, 1 = seg/dig_sel lit when 0; 0 = lit when 1.

Ports:
clk  in  1  fast scan clock
rst  in  1  reset: asynchronous, active-high
bcd_tens  in  4  tens digit; may be asynchronous to clk
bcd_units  in  4  units digit; may be asynchronous to clk
lz_blank_en  in  1  1 = suppress tens digit when it is 0
blink_en  in  1  1 = blink whole display
seg  out  7  {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
dig_sel  out  2  [1] = tens enable, [0] = units enable, polarity per ACTIVE_LOW
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset is asynchronous and active-high. During and after reset:
  - all internal registers are 0; the blink phase is "on"
  - seg and dig_sel are at the unlit level (7'h7F / 2'b11 when ACTIVE_LOW=1, zeros when ACTIVE_LOW=0)
  - frame_tick = 0
  - the displayed value register is 0x00
- Input capture:
  - {bcd_tens, bcd_units} passes through a 2-flop synchroniser (s1, s2) and then a third register s3.
  - A candidate value is valid only when s2 == s3, i.e. stable for 2 consecutive clk cycles. Single-cycle glitches are never displayed.
- Prescaler: div_cnt counts 0..SCAN_DIV-1 and wraps.
- Slot sequencing: at each wrap, slot toggles (0 = tens, 1 = units). A frame is one tens slot followed by one units slot, i.e. 2*SCAN_DIV cycles.
- Frame boundary: the cycle where div_cnt wraps while slot = 1.
  - The displayed value register loads the latest valid candidate only at this boundary. It holds otherwise, so no frame ever mixes two values.
  - frame_tick = 1 in the cycle after each boundary, for exactly 1 cycle.
- Input latency: an input change reaches the display after at most 3 cycles for sync/stability plus up to 1 frame.
- Blanking: while div_cnt < BLANK_CYCLES, both digits are off and seg is unlit.
- Decode (active-high patterns):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - 10..15 = 40 (dash)
- Leading-zero suppression: when lz_blank_en = 1 and the displayed tens = 0, the tens slot keeps dig_sel off and seg unlit. The units digit is always shown, so 0 displays as a single "0". lz_blank_en is sampled live.
- Blink:
  - blink_cnt counts frames, and the blink phase toggles every BLINK_FRAMES frames.
  - While blink_en = 1 and the phase is "off", all digits are dark. frame_tick is unaffected.
  - While blink_en = 0, blink_cnt is held at 0 and the phase is forced "on". Re-enabling therefore always starts with a full "on" phase.
- Output timing: seg, dig_sel and frame_tick are registered. Each output value reflects the div_cnt/slot/state of the previous cycle (fixed 1-cycle lag).
- Polarity: ACTIVE_LOW inversion is applied at the output registers only.
- Mutual exclusion: at most one dig_sel bit is lit in any cycle.
- Reset mid-frame: outputs go unlit immediately (asynchronously), and scanning restarts at the tens slot with div_cnt = 0.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, ACTIVE_LOW=0 unless stated.
1. Hold rst=1 -> seg=00, dig_sel=00, frame_tick=0. Release with inputs tens=4, units=2 held -> from the second frame onward: tens slot shows 2 dark cycles then 6 cycles of dig_sel=10, seg=66; units slot shows 2 dark cycles then 6 cycles of dig_sel=01, seg=5B.
2. Free-run 10 frames -> frame_tick is high exactly 1 cycle every 16 cycles, and dig_sel is never 11.
3. Inputs tens=0, units=7: with lz_blank_en=1 -> tens slot stays dig_sel=00, units slot shows seg=07; with lz_blank_en=0 -> tens slot shows seg=3F.
4. Inputs units=4'hC -> units slot shows seg=40. Then pulse units=5 for 1 cycle only -> display never shows 6D.
5. Change input from 42 to 31 mid-units-slot -> the remainder of the current frame still shows 4/2; the next frame (after any sync delay) shows 4F/06 with no mixed frame.
6. Set blink_en=1 -> 2 frames lit, 2 frames dark, repeating, with frame_tick unchanged. Deassert during a dark phase -> the next frame is lit. Assert rst mid-slot -> outputs unlit in the same cycle.
